keypad_seq_ctrl: RTL
====================

KEYPAD_SEQ_CTRL -- requirements
Module: keypad_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 4: keypad data width in bits.
REQ-002 Parameter DEPTH, default 16: number of stored entries; a power of two, at least 2.
REQ-003 Parameter LOOP, default 0: 1 = playback wraps; 0 = playback ends in IDLE.
REQ-004 clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 dav  in  1  asynchronous data-available level from the keypad; a new key is signalled by its rising edge.
REQ-007 DataIn  in  DATA_W  key code; valid while dav is high.
REQ-008 ModeBtn  in  1  single-cycle, clock-synchronous pulse that advances the mode.
REQ-009 TimerTrigger  in  1  single-cycle, clock-synchronous playback tick.
REQ-010 State  out  2  current state: 0 = IDLE, 1 = WRITE, 2 = READ.
REQ-011 Count  out  log2(DEPTH)+1  number of stored entries.
REQ-012 Full  out  1  high when Count == DEPTH.
REQ-013 Overflow  out  1  one-cycle pulse when a key is dropped because the buffer is full.
REQ-014 DataOut  out  DATA_W  last played-back entry.
REQ-015 DataValid  out  1  one-cycle pulse when DataOut updates.

Function
REQ-016 dav SHALL pass through a 2-flop synchroniser and then a rising-edge detector. DataIn SHALL be pipelined alongside dav, so the captured value is DataIn at the cycle dav was first sampled high.
REQ-017 The key strobe SHALL assert exactly once per dav rising edge, at the 3rd clock edge after dav is first sampled high; a dav held high SHALL produce no further strobes.
REQ-018 FSM transitions on ModeBtn SHALL be: IDLE->WRITE; WRITE->READ; READ->IDLE.
REQ-019 Entering WRITE SHALL clear Count, the write pointer and Full.
REQ-020 In WRITE with Count < DEPTH, each key strobe SHALL store the captured DataIn at the write pointer and increment the pointer and Count in the same cycle.
REQ-021 In WRITE with Count == DEPTH, a key strobe SHALL leave storage and Count unchanged and pulse Overflow for 1 cycle.
REQ-022 Entering READ SHALL clear the read pointer. If Count == 0, the FSM SHALL return to IDLE on the next cycle without asserting DataValid.
REQ-023 In READ, each TimerTrigger SHALL drive DataOut <= mem[rd_ptr] and DataValid = 1 on the next edge, then increment rd_ptr.
REQ-024 When rd_ptr reaches Count: with LOOP = 1, rd_ptr SHALL wrap to 0; with LOOP = 0, the FSM SHALL enter IDLE in the same cycle as the final DataValid.
REQ-025 Key strobes outside WRITE SHALL be ignored. TimerTrigger outside READ SHALL be ignored.
REQ-026 ModeBtn SHALL take priority over a key strobe or TimerTrigger arriving in the same cycle; the coincident strobe or tick SHALL be discarded.
REQ-027 Count and the stored contents SHALL persist through IDLE and READ; only entry to WRITE or reset clears Count.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While reset is high, on every clock edge: State = IDLE, Count = 0, both pointers = 0, Full = 0, Overflow = 0, DataOut = 0, DataValid = 0, synchroniser flops = 0.
REQ-030 Reset SHALL override every other input in any state, including mid-write and mid-playback. Memory contents are not cleared but are unreachable because Count = 0.

Structure
REQ-031 State encodings (IDLE/WRITE/READ) SHALL live in the shared package ctrl_pkg, alongside the default DATA_W and DEPTH.
REQ-032 The dav synchroniser and edge detector SHALL be a sub-module named pulse_sync, parameterised on the data width it carries.
REQ-033 Storage SHALL be an inferred register array of DEPTH x DATA_W with a synchronous write port.

Verification
REQ-034 Reset; ModeBtn; dav rising edges with DataIn 3, 7, 9 -> Count = 3, State = WRITE, each write committed 3 cycles after its dav edge.
REQ-035 DEPTH = 4: write 5 keys -> Count = 4, Full = 1, Overflow pulses once on the 5th key, mem[3] unchanged.
REQ-036 After REQ-034, ModeBtn, then 4 TimerTriggers with LOOP = 0 -> DataOut 3, 7, 9 with DataValid pulses; State = IDLE after the 3rd; the 4th trigger produces no response.
REQ-037 Same sequence with LOOP = 1 -> DataOut 3, 7, 9, 3.
REQ-038 ModeBtn coincident with a key strobe in WRITE -> State = READ, Count unchanged. ModeBtn from IDLE to WRITE to READ with no keys -> IDLE next cycle, no DataValid.
REQ-039 Assert reset during READ mid-playback -> all outputs at reset values on the next edge; a dav held high across reset release -> no strobe.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the keypad sequence controller: FSM state encoding
// and the default data width / storage depth.
package ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } state_e;

    localparam int unsigned DefDataW = 4;
    localparam int unsigned DefDepth = 16;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser plus rising-edge detector for the keypad dav level,
// with the key code pipelined alongside so it is captured where dav was first seen.
module pulse_sync #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             level_i,
    input  logic [Width-1:0] data_i,
    output logic             pulse_o,
    output logic [Width-1:0] data_o
);

    logic             s1_q, s2_q, low_q, pulse_q;
    logic [1:0]       live_q;
    logic [Width-1:0] d1_q, d2_q, data_q;

    // low_q only counts a low that was really sampled after reset, so a level
    // already high when reset is released never looks like a rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            low_q   <= 1'b0;
            pulse_q <= 1'b0;
            live_q  <= 2'b00;
            d1_q    <= '0;
            d2_q    <= '0;
            data_q  <= '0;
        end else begin
            s1_q    <= level_i;
            s2_q    <= s1_q;
            d1_q    <= data_i;
            d2_q    <= d1_q;
            data_q  <= d2_q;
            live_q  <= {live_q[0], 1'b1};
            low_q   <= live_q[1] & ~s2_q;
            pulse_q <= s2_q & low_q;
        end
    end

    assign pulse_o = pulse_q;
    assign data_o  = data_q;

endmodule

// File: rtl/keypad_seq_ctrl.sv
// Keypad sequence recorder: records key codes in WRITE mode and plays them back
// one per timer tick in READ mode, optionally looping.
module keypad_seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned LOOP   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dav,
    input  logic [DATA_W-1:0]        DataIn,
    input  logic                     ModeBtn,
    input  logic                     TimerTrigger,
    output logic [1:0]               State,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Overflow,
    output logic [DATA_W-1:0]        DataOut,
    output logic                     DataValid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   DepthC = DEPTH[AW:0];
    localparam logic [AW:0]   CntOne = 1;
    localparam logic [AW-1:0] PtrOne = 1;

    state_e              state_d, state_q;
    logic [AW:0]         count_d, count_q, rd_next;
    logic [AW-1:0]       wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic                overflow_d, overflow_q, valid_d, valid_q, full_q;
    logic [DATA_W-1:0]   dout_d, dout_q, key_data;
    logic                key_stb, mem_we;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    pulse_sync #(
        .Width (DATA_W)
    ) u_pulse_sync (
        .clk_i   (clock),
        .rst_i   (reset),
        .level_i (dav),
        .data_i  (DataIn),
        .pulse_o (key_stb),
        .data_o  (key_data)
    );

    assign rd_next = {1'b0, rd_ptr_q} + CntOne;

    // ModeBtn is tested first in every state so a coincident key or tick is dropped.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = 1'b0;
        valid_d    = 1'b0;
        dout_d     = dout_q;
        mem_we     = 1'b0;
        case (state_q)
            StIdle: begin
                if (ModeBtn) begin
                    state_d  = StWrite;
                    count_d  = '0;
                    wr_ptr_d = '0;
                end
            end
            StWrite: begin
                if (ModeBtn) begin
                    state_d  = StRead;
                    rd_ptr_d = '0;
                end else if (key_stb) begin
                    if (count_q == DepthC) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrOne;
                        count_d  = count_q + CntOne;
                    end
                end
            end
            StRead: begin
                if (ModeBtn || count_q == '0) begin
                    state_d = StIdle;
                end else if (TimerTrigger) begin
                    dout_d  = mem_q[rd_ptr_q];
                    valid_d = 1'b1;
                    if (rd_next == count_q) begin
                        rd_ptr_d = '0;
                        if (LOOP == 0) begin
                            state_d = StIdle;
                        end
                    end else begin
                        rd_ptr_d = rd_next[AW-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= (count_d == DepthC);
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            dout_q     <= dout_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[wr_ptr_q] <= key_data;
        end
    end

    assign State     = state_q;
    assign Count     = count_q;
    assign Full      = full_q;
    assign Overflow  = overflow_q;
    assign DataOut   = dout_q;
    assign DataValid = valid_q;

endmodule
